// File: rtl/spi_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_regfile
// Purpose  : SPI mode-0 target with an 8-bit register file, oversampled in clk.
//            Optional macro SPI_TGT_AUTOINC_EN: write-burst address auto-increment.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target_regfile #(
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_spi_sclk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  output logic       o_spi_wr_strobe,
  output logic [5:0] o_spi_wr_addr,
  output logic [7:0] o_spi_wr_data,
  output logic       o_spi_rd_strobe,
  output logic [5:0] o_spi_rd_addr,
  input  logic       i_host_wr_en,
  input  logic [5:0] i_host_wr_addr,
  input  logic [7:0] i_host_wr_data,
  input  logic [5:0] i_host_rd_addr,
  output logic [7:0] o_host_rd_data
);

  localparam int C_NUM_ADDR = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_act_prev;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic [5:0] r_addr;

  logic       w_sclk;
  logic       w_cs_act;
  logic       w_mosi;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_fall;
  logic [7:0] w_byte;
  logic [5:0] w_rx_addr;
  logic       w_byte_done;
  logic       w_addr_impl;
  logic       w_spi_we;
  logic [7:0] w_rd_val;
  logic [7:0] w_regs [C_NUM_ADDR];

  // CS synchronizer resets to the inactive (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_act    = ~r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_cs_fall   = w_cs_act & ~r_cs_act_prev;

  assign w_byte      = {r_rx, w_mosi};
  assign w_rx_addr   = w_byte[6:1];
  assign w_byte_done = (r_state != ST_IDLE) && w_cs_act && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_addr_impl = ({1'b0, r_addr} < 7'(DEPTH));
  assign w_spi_we    = w_byte_done && (r_state == ST_WDATA) && w_addr_impl;

  // Unimplemented entries are tied to zero, so reads need no bounds check
  assign w_rd_val       = w_regs[w_rx_addr];
  assign o_host_rd_data = w_regs[i_host_rd_addr];

  for (genvar gi = 0; gi < C_NUM_ADDR; gi++) begin : g_reg
    if (gi < DEPTH) begin : g_impl
      logic [7:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= 8'h00;
        end else if (w_spi_we && (r_addr == 6'(gi))) begin
          r_q <= w_byte;
        end else if (i_host_wr_en && (i_host_wr_addr == 6'(gi))) begin
          r_q <= i_host_wr_data;
        end
      end
      assign w_regs[gi] = r_q;
    end else begin : g_unimpl
      assign w_regs[gi] = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_prev     <= 1'b0;
      r_cs_act_prev   <= 1'b0;
      r_state         <= ST_IDLE;
      r_bit_cnt       <= 3'd0;
      r_rx            <= 7'd0;
      r_tx            <= 8'h00;
      r_addr          <= 6'd0;
      o_spi_miso      <= 1'b0;
      o_spi_miso_oe   <= 1'b0;
      o_spi_wr_strobe <= 1'b0;
      o_spi_wr_addr   <= 6'd0;
      o_spi_wr_data   <= 8'h00;
      o_spi_rd_strobe <= 1'b0;
      o_spi_rd_addr   <= 6'd0;
    end else begin
      r_sclk_prev     <= w_sclk;
      r_cs_act_prev   <= w_cs_act;
      o_spi_miso_oe   <= w_cs_act;
      o_spi_wr_strobe <= 1'b0;
      o_spi_rd_strobe <= 1'b0;

      if (!w_cs_act) begin
        r_state    <= ST_IDLE;
        r_bit_cnt  <= 3'd0;
        r_rx       <= 7'd0;
        r_tx       <= 8'h00;
        o_spi_miso <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state    <= ST_ADDR;
              r_bit_cnt  <= 3'd0;
              r_rx       <= 7'd0;
              r_tx       <= 8'h00;
              o_spi_miso <= 1'b0;
            end
          end
          default: begin
            if (w_sclk_rise) begin
              r_rx      <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                case (r_state)
                  ST_ADDR: begin
                    r_addr <= w_rx_addr;
                    if (w_byte[7]) begin
                      r_state         <= ST_RDATA;
                      r_tx            <= w_rd_val;
                      o_spi_rd_strobe <= 1'b1;
                      o_spi_rd_addr   <= w_rx_addr;
                    end else begin
                      r_state <= ST_WDATA;
                      r_tx    <= 8'h00;
                    end
                  end
                  ST_WDATA: begin
                    r_tx <= 8'h00;
                    if (w_spi_we) begin
                      o_spi_wr_strobe <= 1'b1;
                      o_spi_wr_addr   <= r_addr;
                      o_spi_wr_data   <= w_byte;
                    end
`ifdef SPI_TGT_AUTOINC_EN
                    r_addr <= r_addr + 6'd1;
`else
                    r_addr <= r_addr;
`endif
                  end
                  ST_RDATA: begin
                    // Each byte in a read frame names the next address to fetch
                    r_addr          <= w_rx_addr;
                    r_tx            <= w_rd_val;
                    o_spi_rd_strobe <= 1'b1;
                    o_spi_rd_addr   <= w_rx_addr;
                  end
                  default: begin
                    r_state <= ST_IDLE;
                  end
                endcase
              end
            end else if (w_sclk_fall) begin
              o_spi_miso <= r_tx[7];
              r_tx       <= {r_tx[6:0], 1'b0};
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target_regfile
// Purpose  : Directed bench for spi_target_regfile (DEPTH 64 and DEPTH 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target_regfile;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       host_we;
  logic [5:0] host_wa;
  logic [7:0] host_wd;
  logic [5:0] host_ra;

  logic       miso_a, oe_a, wrs_a, rds_a;
  logic [5:0] wra_a, rda_a;
  logic [7:0] wrd_a, hrd_a;
  logic       miso_b, oe_b, wrs_b, rds_b;
  logic [5:0] wra_b, rda_b;
  logic [7:0] wrd_b, hrd_b;

  int n_cmp = 0;
  int n_bad = 0;

  int         wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0;
  logic [5:0] last_wa_a;
  logic [7:0] last_wd_a;
  logic [5:0] rdlog_a [16];
  logic [5:0] rdlog_b [16];

  spi_target_regfile u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_spi_sclk(sclk), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi),
    .o_spi_miso(miso_a), .o_spi_miso_oe(oe_a),
    .o_spi_wr_strobe(wrs_a), .o_spi_wr_addr(wra_a), .o_spi_wr_data(wrd_a),
    .o_spi_rd_strobe(rds_a), .o_spi_rd_addr(rda_a),
    .i_host_wr_en(host_we), .i_host_wr_addr(host_wa), .i_host_wr_data(host_wd),
    .i_host_rd_addr(host_ra), .o_host_rd_data(hrd_a)
  );

  spi_target_regfile #(.DEPTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .i_spi_sclk(sclk), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi),
    .o_spi_miso(miso_b), .o_spi_miso_oe(oe_b),
    .o_spi_wr_strobe(wrs_b), .o_spi_wr_addr(wra_b), .o_spi_wr_data(wrd_b),
    .o_spi_rd_strobe(rds_b), .o_spi_rd_addr(rda_b),
    .i_host_wr_en(host_we), .i_host_wr_addr(host_wa), .i_host_wr_data(host_wd),
    .i_host_rd_addr(host_ra), .o_host_rd_data(hrd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrs_a) begin
      wr_a++;
      last_wa_a = wra_a;
      last_wd_a = wrd_a;
    end
    if (wrs_b) wr_b++;
    if (rds_a) begin
      rdlog_a[rd_a % 16] = rda_a;
      rd_a++;
    end
    if (rds_b) begin
      rdlog_b[rd_b % 16] = rda_b;
      rd_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] rx_a, output logic [7:0] rx_b);
    rx_a = 8'h00;
    rx_b = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      wait_clk(8);
      rx_a[i] = miso_a;
      rx_b[i] = miso_b;
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end();
    wait_clk(8);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic host_chk(input string tag, input logic [5:0] a,
                          input logic [7:0] e_a, input logic [7:0] e_b);
    host_ra = a;
    #1;
    check({tag, "_d64"}, hrd_a, e_a);
    check({tag, "_d16"}, hrd_b, e_b);
  endtask

  logic [7:0] rx0_a, rx0_b, rx1_a, rx1_b;
  int         base_w, base_w16, base_r, base_r16;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    host_we = 1'b0; host_wa = 6'd0; host_wd = 8'h00; host_ra = 6'd9;
    wait_clk(3);
    check("rst_miso", miso_a, 0);
    check("rst_oe", oe_a, 0);
    check("rst_wrs", wrs_a, 0);
    check("rst_rds", rds_a, 0);
    check("rst_wra", wra_a, 0);
    check("rst_wrd", wrd_a, 0);
    check("rst_rda", rda_a, 0);
    check("rst_hrd", hrd_a, 0);
    rst_n = 1'b1;
    wait_clk(4);

    // single write 0x12 (addr 0x09), 0xA5
    base_w = wr_a;
    frame_begin();
    check("oe_active", oe_a, 1);
    spi_bits(8'h12, 8, rx0_a, rx0_b);
    spi_bits(8'hA5, 8, rx1_a, rx1_b);
    check("wr_miso_b0", rx0_a, 8'h00);
    check("wr_miso_b1", rx1_a, 8'h00);
    frame_end();
    check("wr_cnt", wr_a - base_w, 1);
    check("wr_addr", last_wa_a, 6'h09);
    check("wr_data", last_wd_a, 8'hA5);
    host_chk("wr_reg9", 6'd9, 8'hA5, 8'hA5);

    // read 0x92, 0x00
    base_r = rd_a;
    frame_begin();
    spi_bits(8'h92, 8, rx0_a, rx0_b);
    spi_bits(8'h00, 8, rx1_a, rx1_b);
    frame_end();
    check("rd_b0", rx0_a, 8'h00);
    check("rd_b1", rx1_a, 8'hA5);
    check("rd_cnt", rd_a - base_r, 2);
    check("rd_addr0", rdlog_a[base_r % 16], 6'h09);
    check("rd_addr1", rdlog_a[(base_r + 1) % 16], 6'h00);
    check("oe_idle", oe_a, 0);

    // burst write
    base_w = wr_a;
    frame_begin();
    spi_bits(8'h12, 8, rx0_a, rx0_b);
    spi_bits(8'h01, 8, rx0_a, rx0_b);
    spi_bits(8'h02, 8, rx0_a, rx0_b);
    spi_bits(8'h03, 8, rx0_a, rx0_b);
    frame_end();
    check("burst_cnt", wr_a - base_w, 3);
`ifdef SPI_TGT_AUTOINC_EN
    host_chk("burst_r9", 6'd9, 8'h01, 8'h01);
    host_chk("burst_rA", 6'd10, 8'h02, 8'h02);
    host_chk("burst_rB", 6'd11, 8'h03, 8'h03);
    check("burst_last_addr", last_wa_a, 6'h0B);
`else
    host_chk("burst_r9", 6'd9, 8'h03, 8'h03);
    host_chk("burst_rA", 6'd10, 8'h00, 8'h00);
    check("burst_last_addr", last_wa_a, 6'h09);
`endif

    // CS rise after 5 bits of a data byte
    base_w = wr_a;
    frame_begin();
    spi_bits(8'h12, 8, rx0_a, rx0_b);
    spi_bits(8'hFF, 5, rx0_a, rx0_b);
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(4);
    check("abort_oe", oe_a, 0);
    wait_clk(8);
    check("abort_cnt", wr_a - base_w, 0);
`ifdef SPI_TGT_AUTOINC_EN
    host_chk("abort_r9", 6'd9, 8'h01, 8'h01);
`else
    host_chk("abort_r9", 6'd9, 8'h03, 8'h03);
`endif

    // unimplemented address on the DEPTH=16 instance
    base_w = wr_a; base_w16 = wr_b;
    frame_begin();
    spi_bits(8'h40, 8, rx0_a, rx0_b);
    spi_bits(8'h55, 8, rx0_a, rx0_b);
    frame_end();
    check("unimpl_wr16", wr_b - base_w16, 0);
    check("unimpl_wr64", wr_a - base_w, 1);
    check("unimpl_wa64", last_wa_a, 6'h20);
    host_chk("unimpl_r20", 6'h20, 8'h55, 8'h00);
    base_r16 = rd_b;
    frame_begin();
    spi_bits(8'hC0, 8, rx0_a, rx0_b);
    spi_bits(8'h00, 8, rx1_a, rx1_b);
    frame_end();
    check("unimpl_rd64", rx1_a, 8'h55);
    check("unimpl_rd16", rx1_b, 8'h00);
    check("unimpl_rdcnt16", rd_b - base_r16, 2);
    check("unimpl_rdaddr16", rdlog_b[base_r16 % 16], 6'h20);

    // host write then SPI read of the same register
    @(posedge clk); #1;
    host_we = 1'b1; host_wa = 6'd5; host_wd = 8'h3C;
    wait_clk(1);
    host_we = 1'b0;
    host_chk("host_r5", 6'd5, 8'h3C, 8'h3C);
    frame_begin();
    spi_bits(8'h8A, 8, rx0_a, rx0_b);
    spi_bits(8'h00, 8, rx1_a, rx1_b);
    frame_end();
    check("host_spi_rd64", rx1_a, 8'h3C);
    check("host_spi_rd16", rx1_b, 8'h3C);

    // reset mid-frame, then a normal frame
    frame_begin();
    spi_bits(8'h12, 3, rx0_a, rx0_b);
    check("mid_oe_before", oe_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid_oe", oe_a, 0);
    check("mid_miso", miso_a, 0);
    host_chk("mid_r9", 6'd9, 8'h00, 8'h00);
    wait_clk(3);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(8);
    base_w = wr_a;
    frame_begin();
    spi_bits(8'h12, 8, rx0_a, rx0_b);
    spi_bits(8'h77, 8, rx0_a, rx0_b);
    frame_end();
    check("post_rst_cnt", wr_a - base_w, 1);
    host_chk("post_rst_r9", 6'd9, 8'h77, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
